ps2_quad_mouse: RTL and testbench
=================================

PS2_QUAD_MOUSE -- requirements
Module: ps2_quad_mouse

Interface
REQ-001 Parameter ACC_W, default 12: per-axis signed accumulator width, legal range 10..16.
REQ-002 Parameter DIV_W, default 10: step prescaler width.
REQ-003 Port clk, input, 1: the single clock; all state is clocked on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port ps2_mouse, input, 25: MiSTer mouse packet. [24] toggle strobe; [23:16] Y delta; [15:8] X delta; [7] Y overflow; [6] X overflow; [5] Y sign; [4] X sign; [2:0] buttons M/R/L.
REQ-006 Port ps2_mouse_ext, input, 16: extension word; [7:0] is the signed wheel delta; used only under PS2_QUAD_WHEEL_EN.
REQ-007 Port step_div, input, DIV_W: step period; one step tick occurs every step_div+1 cycles.
REQ-008 Port mouse_atari, output, 6: {buttons[1:0], y_phase[1:0], x_phase[1:0]}.
REQ-009 Port wheel_phase, output, 2: wheel quadrature phase; tied to 2'b00 without the macro.
REQ-010 Port busy, output, 1: high while any accumulator is non-zero.

Function
REQ-011 Strobe detect: a packet is accepted on the first clk where ps2_mouse[24] differs from its registered previous value.
REQ-012 Delta formation:
- X = sign-extended {[4],[15:8]}.
- Y = two's-complement negation of sign-extended {[5],[23:16]}.
- Wheel = sign-extended [7:0] of ps2_mouse_ext.
REQ-013 On acceptance, each axis adds its delta to its accumulator and saturates at +/-(2^(ACC_W-1)-1); the accumulator never wraps.
REQ-014 If an axis's overflow bit ([6] X, [7] Y) is set, that axis ignores the packet's delta; other axes still accumulate.
REQ-015 Buttons: mouse_atari[5:4] is loaded from ps2_mouse[1:0] on acceptance and otherwise holds.
REQ-016 Prescaler: counts 0..step_div; it asserts tick and returns to 0 on the cycle it equals step_div. step_div=0 gives a tick every cycle.
REQ-017 A step_div change takes effect at the next wrap. If the prescaler is already above the new value, it wraps at 2^DIV_W-1.
REQ-018 On tick, each axis with a positive accumulator decrements by 1 and advances its phase 00->10->11->01->00.
REQ-019 On tick, each axis with a negative accumulator increments by 1 and advances its phase 00->01->11->10->00.
REQ-020 On tick, an axis with a zero accumulator holds its phase.
REQ-021 If acceptance and tick coincide on one axis:
- next acc = sat(acc + delta - step), where step is the sign of the pre-update accumulator;
- the phase advances per that same step.
REQ-022 The phase changes at most once per tick; the latency from acceptance to the first phase edge is at most step_div+1 cycles.
REQ-023 busy is combinational: the OR of all accumulators being non-zero.

Reset
REQ-024 While reset_n is low:
- accumulators, prescaler, strobe history and buttons are 0;
- all phases are 00; mouse_atari=6'b0, wheel_phase=2'b0, busy=0.
REQ-025 Reset asserted mid-step discards pending motion; after release, the first strobe toggle relative to the sampled strobe level is the first packet accepted.

Configuration
REQ-026 Macro PS2_QUAD_WHEEL_EN.
- Defined: a third axis accumulates the wheel delta per REQ-013/018/019/021 and drives wheel_phase; ps2_mouse_ext is sampled on acceptance.
- Undefined: no wheel logic is built, ps2_mouse_ext is unused, wheel_phase=2'b00, and busy covers X/Y only.

Structure
REQ-027 Package ps2_quad_pkg holds:
- typedef quad_phase_t (2-bit);
- the forward and reverse Gray successor constants;
- a saturating-add function parameterised by ACC_W.
REQ-028 Sub-module ps2_quad_axis contains one accumulator plus its phase stepper, with inputs load, delta, tick and outputs phase, nonzero; it is instantiated once per axis.

Verification
REQ-029 X=+3 packet, step_div=3: x_phase goes 00->10->11->01 on ticks 4, 8, 12 cycles after acceptance; busy falls after the third step.
REQ-030 Y sign=1, delta 8'hFE (-2): Y accumulator becomes +2 after inversion; y_phase goes 00->10->11; x_phase stays 00.
REQ-031 ACC_W=10, five packets of X=+255 each with step_div max: accumulator saturates at 511, not 1275 and not wrapped.
REQ-032 Packet with [6]=1, X=+50, Y=+4: X accumulator stays 0; Y gets -4 and y_phase steps 01,11,10,00.
REQ-033 Acceptance on the same cycle as a tick with acc=+1 and delta=+1: acc becomes 1 and x_phase advances one state.
REQ-034 reset_n pulsed low mid-motion with acc=+20: all outputs are 0 immediately, busy=0; with PS2_QUAD_WHEEL_EN, a wheel -1 packet then gives wheel_phase 01.

Source files
------------

// File: rtl/ps2_quad_pkg.sv
// Shared types, Gray-code successor tables and saturating arithmetic for the
// PS/2-to-quadrature mouse converter.
package ps2_quad_pkg;

  typedef logic [1:0] quad_phase_t;

  localparam int DELTA_W = 10;

  // Indexed by the current phase: forward walks 00->10->11->01, reverse 00->01->11->10.
  localparam logic [3:0][1:0] QUAD_FWD_SUCC = {2'b01, 2'b11, 2'b00, 2'b10};
  localparam logic [3:0][1:0] QUAD_REV_SUCC = {2'b10, 2'b00, 2'b11, 2'b01};

  // Adds two signed values and clamps the result to +/-(2^(acc_w-1)-1).
  function automatic logic signed [16:0] sat_add(input logic signed [16:0] a,
                                                 input logic signed [16:0] b,
                                                 input int acc_w);
    logic signed [17:0] sum;
    logic signed [17:0] lim;
    logic signed [17:0] neg;
    sum = {a[16], a} + {b[16], b};
    lim = (18'sd1 <<< (acc_w - 1)) - 18'sd1;
    neg = -lim;
    if (sum > lim)      return lim[16:0];
    else if (sum < neg) return neg[16:0];
    else                return sum[16:0];
  endfunction

endpackage

// File: rtl/ps2_quad_axis.sv
// One motion axis: a saturating signed accumulator drained one count per tick,
// with a Gray-code phase stepper following the drain direction.
module ps2_quad_axis
  import ps2_quad_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                      tick,
  output quad_phase_t               phase,
  output logic                      nonzero
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  quad_phase_t             phase_q, phase_d;
  logic signed [16:0]      acc_ext, delta_ext, stepped;

  // The step direction comes from the pre-update accumulator, so a packet
  // landing on a tick still produces exactly one phase edge.
  always_comb begin
    phase_d   = phase_q;
    acc_ext   = {{(17 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    delta_ext = {{(17 - DELTA_W){delta[DELTA_W-1]}}, delta};
    stepped   = acc_ext;
    if (tick && (acc_q != '0)) begin
      if (!acc_q[ACC_W-1]) begin
        stepped = acc_ext - 17'sd1;
        phase_d = QUAD_FWD_SUCC[phase_q];
      end else begin
        stepped = acc_ext + 17'sd1;
        phase_d = QUAD_REV_SUCC[phase_q];
      end
    end
    acc_d = load ? ACC_W'(sat_add(stepped, delta_ext, ACC_W)) : ACC_W'(stepped);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      phase_q <= 2'b00;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign nonzero = (acc_q != '0);

endmodule

// File: rtl/ps2_quad_mouse.sv
// MiSTer PS/2 mouse packets to Atari-style quadrature outputs.
// Optional wheel axis enabled by defining PS2_QUAD_WHEEL_EN.
module ps2_quad_mouse
  import ps2_quad_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [24:0]      ps2_mouse,
  input  logic [15:0]      ps2_mouse_ext,
  input  logic [DIV_W-1:0] step_div,
  output logic [5:0]       mouse_atari,
  output logic [1:0]       wheel_phase,
  output logic             busy
);

  logic                      strobe_q, primed_q;
  logic [1:0]                btn_q;
  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic                      tick, accept;
  logic signed [DELTA_W-1:0] x_delta, y_delta;
  quad_phase_t               x_phase, y_phase;
  logic                      x_nz, y_nz, w_nz;
  logic                      unused_bits;

  // The first cycle after reset only samples the strobe level, so a strobe
  // that was already high is not mistaken for a new packet.
  assign accept = primed_q && (ps2_mouse[24] != strobe_q);

  // Counting past the maximum wraps through zero even if step_div shrank below
  // the current count.
  assign tick  = (cnt_q == step_div) || (cnt_q == '1);
  assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      primed_q <= 1'b0;
      btn_q    <= 2'b00;
      cnt_q    <= '0;
    end else begin
      strobe_q <= ps2_mouse[24];
      primed_q <= 1'b1;
      cnt_q    <= cnt_d;
      if (accept) btn_q <= ps2_mouse[1:0];
    end
  end

  assign x_delta = {ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:8]};
  assign y_delta = -{ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:16]};

  ps2_quad_axis #(.ACC_W(ACC_W)) u_x (
    .clk(clk), .reset_n(reset_n), .load(accept && !ps2_mouse[6]),
    .delta(x_delta), .tick(tick), .phase(x_phase), .nonzero(x_nz)
  );

  ps2_quad_axis #(.ACC_W(ACC_W)) u_y (
    .clk(clk), .reset_n(reset_n), .load(accept && !ps2_mouse[7]),
    .delta(y_delta), .tick(tick), .phase(y_phase), .nonzero(y_nz)
  );

`ifdef PS2_QUAD_WHEEL_EN
  quad_phase_t               w_phase;
  logic signed [DELTA_W-1:0] w_delta;

  assign w_delta = {{(DELTA_W - 8){ps2_mouse_ext[7]}}, ps2_mouse_ext[7:0]};

  ps2_quad_axis #(.ACC_W(ACC_W)) u_w (
    .clk(clk), .reset_n(reset_n), .load(accept),
    .delta(w_delta), .tick(tick), .phase(w_phase), .nonzero(w_nz)
  );

  assign wheel_phase = w_phase;
  assign unused_bits = ^{ps2_mouse[3:2], ps2_mouse_ext[15:8]};
`else
  assign w_nz        = 1'b0;
  assign wheel_phase = 2'b00;
  assign unused_bits = ^{ps2_mouse[3:2], ps2_mouse_ext};
`endif

  assign mouse_atari = {btn_q, y_phase, x_phase};
  assign busy        = x_nz || y_nz || w_nz;

endmodule

// File: tb/tb_ps2_quad_mouse.sv
// Directed bench for ps2_quad_mouse (ACC_W=10) with hand-computed phase sequences.
module tb_ps2_quad_mouse;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic [15:0] ps2_mouse_ext = '0;
  logic [9:0]  step_div = '0;
  logic [5:0]  mouse_atari;
  logic [1:0]  wheel_phase;
  logic        busy;
  logic        strobe = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  ps2_quad_mouse #(.ACC_W(10), .DIV_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
    .ps2_mouse_ext(ps2_mouse_ext), .step_div(step_div),
    .mouse_atari(mouse_atari), .wheel_phase(wheel_phase), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cur_phase(input int sel);
    if (sel == 0)      return mouse_atari[1:0];
    else if (sel == 1) return mouse_atari[3:2];
    else               return wheel_phase;
  endfunction

  task automatic do_reset(input logic [9:0] div);
    reset_n  = 1'b0;
    step_div = div;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Toggles the strobe; the packet is accepted on the following rising edge.
  task automatic send_pkt(input logic [8:0] x, input logic [8:0] y, input logic xo,
                          input logic yo, input logic [1:0] btn, input logic [7:0] wh);
    strobe        = ~strobe;
    ps2_mouse     = {strobe, y[7:0], x[7:0], yo, xo, y[8], x[8], 2'b00, btn};
    ps2_mouse_ext = {8'h00, wh};
    @(posedge clk); #1;
  endtask

  task automatic wait_change(input int sel, input int limit, output int cycles);
    logic [1:0] start;
    bit         done;
    start  = cur_phase(sel);
    cycles = -1;
    done   = 0;
    for (int i = 1; i <= limit && !done; i++) begin
      @(posedge clk); #1;
      if (cur_phase(sel) != start) begin
        cycles = i;
        done   = 1;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    n_cmp++; if (mouse_atari !== 6'b0) begin n_bad++; $display("[TB] FAIL reset_atari got=%b exp=000000", mouse_atari); end
    n_cmp++; if (wheel_phase !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_wheel got=%b exp=00", wheel_phase); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_x_steps;
    logic [1:0] exp_seq [3] = '{2'b10, 2'b11, 2'b01};
    int c;
    do_reset(10'd3);
    send_pkt(9'd3, 9'd0, 1'b0, 1'b0, 2'b01, 8'h00);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL x_busy_on got=%b exp=1", busy); end
    n_cmp++; if (mouse_atari[5:4] !== 2'b01) begin n_bad++; $display("[TB] FAIL x_buttons got=%b exp=01", mouse_atari[5:4]); end
    for (int k = 0; k < 3; k++) begin
      wait_change(0, 6, c);
      n_cmp++; if (mouse_atari[1:0] !== exp_seq[k]) begin n_bad++; $display("[TB] FAIL x_phase%0d got=%b exp=%b", k, mouse_atari[1:0], exp_seq[k]); end
      if (k == 0) begin
        n_cmp++; if (c < 1 || c > 4) begin n_bad++; $display("[TB] FAIL x_latency got=%0d exp=1..4", c); end
      end else begin
        n_cmp++; if (c !== 4) begin n_bad++; $display("[TB] FAIL x_spacing%0d got=%0d exp=4", k, c); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL x_busy_off got=%b exp=0", busy); end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (mouse_atari[1:0] !== 2'b01) begin n_bad++; $display("[TB] FAIL x_hold got=%b exp=01", mouse_atari[1:0]); end
  endtask

  task automatic test_y_inverted;
    logic [1:0] exp_seq [2] = '{2'b10, 2'b11};
    int c;
    do_reset(10'd1);
    send_pkt(9'd0, 9'h1FE, 1'b0, 1'b0, 2'b10, 8'h00);
    for (int k = 0; k < 2; k++) begin
      wait_change(1, 4, c);
      n_cmp++; if (mouse_atari[3:2] !== exp_seq[k]) begin n_bad++; $display("[TB] FAIL y_phase%0d got=%b exp=%b", k, mouse_atari[3:2], exp_seq[k]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL y_busy_off got=%b exp=0", busy); end
    n_cmp++; if (mouse_atari[1:0] !== 2'b00) begin n_bad++; $display("[TB] FAIL y_xstill got=%b exp=00", mouse_atari[1:0]); end
  endtask

  task automatic test_overflow;
    logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int c;
    do_reset(10'd1);
    send_pkt(9'd50, 9'd4, 1'b1, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_change(1, 4, c);
      n_cmp++; if (mouse_atari[3:2] !== exp_seq[k]) begin n_bad++; $display("[TB] FAIL ovf_yphase%0d got=%b exp=%b", k, mouse_atari[3:2], exp_seq[k]); end
    end
    n_cmp++; if (mouse_atari[1:0] !== 2'b00) begin n_bad++; $display("[TB] FAIL ovf_xphase got=%b exp=00", mouse_atari[1:0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_busy got=%b exp=0", busy); end
  endtask

  task automatic test_coincide;
    int c;
    do_reset(10'd3);
    send_pkt(9'd2, 9'd0, 1'b0, 1'b0, 2'b00, 8'h00);
    wait_change(0, 6, c);
    n_cmp++; if (mouse_atari[1:0] !== 2'b10) begin n_bad++; $display("[TB] FAIL co_first got=%b exp=10", mouse_atari[1:0]); end
    repeat (3) @(posedge clk);
    #1;
    send_pkt(9'd1, 9'd0, 1'b0, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (mouse_atari[1:0] !== 2'b11) begin n_bad++; $display("[TB] FAIL co_step got=%b exp=11", mouse_atari[1:0]); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL co_busy got=%b exp=1", busy); end
    wait_change(0, 6, c);
    n_cmp++; if (c !== 4 || mouse_atari[1:0] !== 2'b01) begin n_bad++; $display("[TB] FAIL co_last got=%0d/%b exp=4/01", c, mouse_atari[1:0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL co_drained got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int c;
    do_reset(10'd1023);
    send_pkt(9'd20, 9'd0, 1'b0, 1'b0, 2'b11, 8'h00);
    n_cmp++; if (busy !== 1'b1 || mouse_atari[5:4] !== 2'b11) begin n_bad++; $display("[TB] FAIL rm_pre got=%b/%b exp=1/11", busy, mouse_atari[5:4]); end
    @(posedge clk); #3;
    reset_n   = 1'b0;
    strobe    = 1'b1;
    ps2_mouse = {1'b1, 8'h00, 8'h05, 8'h03};
    #1;
    n_cmp++; if (mouse_atari !== 6'b0) begin n_bad++; $display("[TB] FAIL rm_atari got=%b exp=000000", mouse_atari); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rm_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset_n  = 1'b1;
    step_div = 10'd0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || mouse_atari !== 6'b0) begin n_bad++; $display("[TB] FAIL rm_nospurious got=%b/%b exp=0/000000", busy, mouse_atari); end
    send_pkt(9'd0, 9'd0, 1'b0, 1'b0, 2'b00, 8'hFF);
`ifdef PS2_QUAD_WHEEL_EN
    wait_change(2, 4, c);
    n_cmp++; if (wheel_phase !== 2'b01) begin n_bad++; $display("[TB] FAIL rm_wheel got=%b exp=01 (%0d cyc)", wheel_phase, c); end
`else
    c = 0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (wheel_phase !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rm_nowheel got=%b/%b exp=00/0 (%0d)", wheel_phase, busy, c); end
`endif
  endtask

  task automatic test_saturate;
    int         steps;
    bit         done;
    logic [1:0] prev;
    do_reset(10'd1023);
    for (int k = 0; k < 5; k++) send_pkt(9'd255, 9'd0, 1'b0, 1'b0, 2'b00, 8'h00);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_busy got=%b exp=1", busy); end
    step_div = 10'd0;
    steps = 0;
    done  = 0;
    prev  = mouse_atari[1:0];
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (mouse_atari[1:0] != prev) steps++;
      prev = mouse_atari[1:0];
      if (!busy) done = 1;
    end
    n_cmp++; if (!done) begin n_bad++; $display("[TB] FAIL sat_timeout got=busy exp=idle"); end
    n_cmp++; if (steps !== 511) begin n_bad++; $display("[TB] FAIL sat_steps got=%0d exp=511", steps); end
    n_cmp++; if (mouse_atari[1:0] !== 2'b01) begin n_bad++; $display("[TB] FAIL sat_phase got=%b exp=01", mouse_atari[1:0]); end
  endtask

  initial begin
    test_reset;
    test_x_steps;
    test_y_inverted;
    test_overflow;
    test_coincide;
    test_reset_mid;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
